victim_evict_buffer: RTL and testbench

Eviction-side feeder for the L1 data cache's victim cache. It accepts lines evicted by the L1 refill logic into a small FIFO. It writes each line into the victim cache through that cache's unconditional `wen/data_in/tag_in` write port. For dirty lines, it then drains the line word-by-word to L2 over a valid/ready write channel. It sits between the L1 miss handler and both the victim cache and the L2 write path, and guarantees that each line lands in the victim cache before its L2 write-back starts.

---
 rtl/victim_evict_buffer_pkg.sv | 10 +
 rtl/victim_evict_buffer_fifo.sv | 82 ++++++++
 rtl/victim_evict_buffer.sv | 157 +++++++++++++++
 tb/tb_victim_evict_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_evict_buffer_pkg.sv
// Shared types for the L1 victim-eviction path.
package RVS192_package;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VC,
        S_WB
    } veb_state_e;

endpackage

// File: rtl/victim_evict_buffer_fifo.sv
// Eviction entry FIFO: data/tag/dirty storage with wrap-bit pointers,
// head entry view and per-entry valid/tag/dirty for victim-tag lookup.
module veb_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned TAG_W  = 26
) (
    input  logic                   clk_l1,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic [TAG_W-1:0]       push_tag,
    input  logic                   push_dirty,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [DATA_W-1:0]      head_data,
    output logic [TAG_W-1:0]       head_tag,
    output logic                   head_dirty,
    output logic [DEPTH-1:0]       ent_valid,
    output logic [DEPTH*TAG_W-1:0] ent_tag,
    output logic [DEPTH-1:0]       ent_dirty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count;
    logic [AW-1:0]     rel [DEPTH];
    logic              do_push;
    logic              do_pop;

    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_mem   [DEPTH];
    logic              dirty_mem [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_l1) begin
        if (do_push) begin
            data_mem[wr_ptr_q[AW-1:0]]  <= push_data;
            tag_mem[wr_ptr_q[AW-1:0]]   <= push_tag;
            dirty_mem[wr_ptr_q[AW-1:0]] <= push_dirty;
        end
    end

    assign head_data  = data_mem[rd_ptr_q[AW-1:0]];
    assign head_tag   = tag_mem[rd_ptr_q[AW-1:0]];
    assign head_dirty = dirty_mem[rd_ptr_q[AW-1:0]];

    // An entry is live when its distance from the read slot is below the occupancy.
    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rel[i]                     = AW'(i) - rd_ptr_q[AW-1:0];
            ent_valid[i]               = ({1'b0, rel[i]} < count);
            ent_tag[i*TAG_W +: TAG_W]  = tag_mem[i];
            ent_dirty[i]               = dirty_mem[i];
        end
    end

endmodule

// File: rtl/victim_evict_buffer.sv
// Victim eviction buffer: queues evicted L1 lines, writes each into the victim
// cache, then drains dirty lines to L2. Optional tag lookup: VEB_LOOKUP_EN.
module victim_evict_buffer
    import RVS192_package::*;
#(
    parameter int unsigned SLOT         = 4,
    parameter int unsigned DATA_LENGTH  = 32,
    parameter int unsigned VCTAG_LENGTH = 26,
    parameter int unsigned ADDR_LENGTH  = 32,
    parameter int unsigned FIFO_DEPTH   = 2
) (
    input  logic                          clk_l1,
    input  logic                          rst_n,
    input  logic                          evict_valid,
    output logic                          evict_ready,
    input  logic [SLOT*DATA_LENGTH-1:0]   evict_data,
    input  logic [VCTAG_LENGTH-1:0]       evict_tag,
    input  logic                          evict_dirty,
    output logic                          vc_wen,
    output logic [SLOT*DATA_LENGTH-1:0]   vc_data_in,
    output logic [VCTAG_LENGTH-1:0]       vc_tag_in,
    output logic                          l2_wvalid,
    input  logic                          l2_wready,
    output logic [ADDR_LENGTH-1:0]        l2_waddr,
    output logic [DATA_LENGTH-1:0]        l2_wdata,
    output logic                          l2_wlast,
    input  logic [VCTAG_LENGTH-1:0]       lookup_tag,
    output logic                          lookup_hit,
    output logic                          busy
);

    localparam int unsigned    WCW       = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(SLOT - 1);
    localparam int unsigned    LINE_W    = SLOT * DATA_LENGTH;

    logic                             fifo_full, fifo_empty, pop;
    logic [LINE_W-1:0]                head_data;
    logic [VCTAG_LENGTH-1:0]          head_tag;
    logic                             head_dirty;
    logic [FIFO_DEPTH-1:0]            ent_valid;
    logic [FIFO_DEPTH*VCTAG_LENGTH-1:0] ent_tag;
    logic [FIFO_DEPTH-1:0]            ent_dirty;

    veb_state_e     state_q, state_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic           vc_wen_q, vc_wen_d;
    logic           l2_wvalid_q, l2_wvalid_d;
    logic           l2_wlast_q, l2_wlast_d;

    veb_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (LINE_W),
        .TAG_W  (VCTAG_LENGTH)
    ) u_fifo (
        .clk_l1     (clk_l1),
        .rst_n      (rst_n),
        .push       (evict_valid),
        .push_data  (evict_data),
        .push_tag   (evict_tag),
        .push_dirty (evict_dirty),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head_data  (head_data),
        .head_tag   (head_tag),
        .head_dirty (head_dirty),
        .ent_valid  (ent_valid),
        .ent_tag    (ent_tag),
        .ent_dirty  (ent_dirty)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_VC;
            end
            S_VC: begin
                if (head_dirty) begin
                    word_cnt_d = '0;
                    state_d    = S_WB;
                end else begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (l2_wready) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered from the next state so they align with it.
        vc_wen_d    = (state_d == S_VC);
        l2_wvalid_d = (state_d == S_WB);
        l2_wlast_d  = (state_d == S_WB) && (word_cnt_d == LAST_WORD);
    end

    always_ff @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            vc_wen_q    <= 1'b0;
            l2_wvalid_q <= 1'b0;
            l2_wlast_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            vc_wen_q    <= vc_wen_d;
            l2_wvalid_q <= l2_wvalid_d;
            l2_wlast_q  <= l2_wlast_d;
        end
    end

    assign evict_ready = !fifo_full;
    assign busy        = !fifo_empty || (state_q != S_IDLE);
    assign vc_wen      = vc_wen_q;
    assign vc_data_in  = head_data;
    assign vc_tag_in   = head_tag;
    assign l2_wvalid   = l2_wvalid_q;
    assign l2_wlast    = l2_wlast_q;
    assign l2_waddr    = {head_tag, {(ADDR_LENGTH-VCTAG_LENGTH){1'b0}}}
                       + (ADDR_LENGTH'(word_cnt_q) * ADDR_LENGTH'(DATA_LENGTH / 8));

    always_comb begin
        l2_wdata = '0;
        for (int unsigned w = 0; w < SLOT; w++) begin
            if (word_cnt_q == WCW'(w)) l2_wdata = head_data[w*DATA_LENGTH +: DATA_LENGTH];
        end
    end

`ifdef VEB_LOOKUP_EN
    always_comb begin
        lookup_hit = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_tag[i*VCTAG_LENGTH +: VCTAG_LENGTH] == lookup_tag))
                lookup_hit = 1'b1;
        end
    end

    logic unused_ent_dirty;
    assign unused_ent_dirty = ^ent_dirty;
`else
    assign lookup_hit = 1'b0;

    logic unused_lookup;
    assign unused_lookup = ^{lookup_tag, ent_valid, ent_tag, ent_dirty};
`endif

endmodule

// File: tb/tb_victim_evict_buffer.sv
// Bench for victim_evict_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_victim_evict_buffer;

    localparam int SLOT  = 4;
    localparam int DL    = 32;
    localparam int TL    = 26;
    localparam int AL    = 32;
    localparam int DEPTH = 2;
`ifdef VEB_LOOKUP_EN
    localparam bit LOOKUP_ON = 1'b1;
`else
    localparam bit LOOKUP_ON = 1'b0;
`endif

    logic                 clk_l1, rst_n;
    logic                 evict_valid, evict_ready, evict_dirty;
    logic [SLOT*DL-1:0]   evict_data, vc_data_in;
    logic [TL-1:0]        evict_tag, vc_tag_in, lookup_tag;
    logic                 vc_wen, l2_wvalid, l2_wready, l2_wlast, lookup_hit, busy;
    logic [AL-1:0]        l2_waddr;
    logic [DL-1:0]        l2_wdata;

    victim_evict_buffer #(
        .SLOT(SLOT), .DATA_LENGTH(DL), .VCTAG_LENGTH(TL), .ADDR_LENGTH(AL), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_l1(clk_l1), .rst_n(rst_n),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_data(evict_data),
        .evict_tag(evict_tag), .evict_dirty(evict_dirty),
        .vc_wen(vc_wen), .vc_data_in(vc_data_in), .vc_tag_in(vc_tag_in),
        .l2_wvalid(l2_wvalid), .l2_wready(l2_wready), .l2_waddr(l2_waddr),
        .l2_wdata(l2_wdata), .l2_wlast(l2_wlast),
        .lookup_tag(lookup_tag), .lookup_hit(lookup_hit), .busy(busy)
    );

    initial clk_l1 = 1'b0;
    always #5 clk_l1 = ~clk_l1;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending lines; stage -1 = waiting for a line,
    // 0 = victim-cache write cycle, n>0 = presenting word n-1 to L2.
    typedef struct {
        logic [SLOT*DL-1:0] data;
        logic [TL-1:0]      tag;
        logic               dirty;
    } ent_t;

    ent_t mq[$];
    int   stage = -1;

    always @(posedge clk_l1 or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            stage = -1;
        end else begin
            bit   take;
            ent_t e;
            take = evict_valid && (mq.size() < DEPTH);
            if (stage < 0) begin
                if (mq.size() > 0) stage = 0;
            end else if (stage == 0) begin
                if (mq[0].dirty) stage = 1;
                else begin
                    void'(mq.pop_front());
                    stage = -1;
                end
            end else if (l2_wready) begin
                if (stage == SLOT) begin
                    void'(mq.pop_front());
                    stage = -1;
                end else stage++;
            end
            if (take) begin
                e.data  = evict_data;
                e.tag   = evict_tag;
                e.dirty = evict_dirty;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk_l1) begin
        logic          exp_vc, exp_wv, exp_last, exp_hit;
        int            w;
        logic [AL-1:0] ea;
        logic [DL-1:0] ed;
        exp_vc   = (stage == 0);
        exp_wv   = (stage >= 1);
        w        = stage - 1;
        exp_last = exp_wv && (w == SLOT - 1);
        exp_hit  = 1'b0;
        if (LOOKUP_ON) foreach (mq[i]) if (mq[i].tag == lookup_tag) exp_hit = 1'b1;
        chk("m_vc_wen", vc_wen, exp_vc);
        chk("m_l2_wvalid", l2_wvalid, exp_wv);
        chk("m_l2_wlast", l2_wlast, exp_last);
        chk("m_evict_ready", evict_ready, mq.size() < DEPTH);
        chk("m_busy", busy, (mq.size() > 0) || (stage >= 0));
        chk("m_lookup_hit", lookup_hit, exp_hit);
        if (exp_vc) begin
            chk("m_vc_tag", vc_tag_in, mq[0].tag);
            chk("m_vc_data", vc_data_in, mq[0].data);
        end
        if (exp_wv) begin
            ea = (AL'(mq[0].tag) << (AL - TL)) + AL'(w * (DL / 8));
            ed = DL'(mq[0].data >> (DL * w));
            chk("m_l2_waddr", l2_waddr, ea);
            chk("m_l2_wdata", l2_wdata, ed);
        end
    end

    task automatic tick();
        @(posedge clk_l1);
        #2;
    endtask

    task automatic drive_line(input logic [TL-1:0] t, input logic [SLOT*DL-1:0] d, input logic dty);
        evict_valid = 1'b1;
        evict_tag   = t;
        evict_data  = d;
        evict_dirty = dty;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) tick();
        chk("wait_idle", busy, 1'b0);
    endtask

    function automatic logic [SLOT*DL-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [AL-1:0]  ad [8];
    logic [7:0]     lastv;
    logic [DL-1:0]  wd0;
    logic [AL-1:0]  base, hold_a;
    logic [DL-1:0]  hold_d;
    logic [TL-1:0]  tags [4];
    int             n, first_vc, first_wv;

    initial begin
        rst_n = 1'b0; evict_valid = 1'b0; evict_data = '0; evict_tag = '0;
        evict_dirty = 1'b0; l2_wready = 1'b0; lookup_tag = '0;
        tick(); tick();
        chk("rst_evict_ready", evict_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_vc_wen", vc_wen, 1'b0);
        chk("rst_l2_wvalid", l2_wvalid, 1'b0);
        chk("rst_l2_wlast", l2_wlast, 1'b0);
        chk("rst_lookup_hit", lookup_hit, 1'b0);
        rst_n = 1'b1;
        tick();

        // Clean line
        drive_line(26'h0ABCDEF, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0);
        tick();
        evict_valid = 1'b0;
        chk("t1_vc_wen_k", vc_wen, 1'b0);
        tick();
        chk("t1_vc_wen_k1", vc_wen, 1'b1);
        chk("t1_vc_tag", vc_tag_in, 26'h0ABCDEF);
        chk("t1_vc_data", vc_data_in, {32'd4, 32'd3, 32'd2, 32'd1});
        tick();
        chk("t1_vc_wen_k2", vc_wen, 1'b0);
        tick();
        chk("t1_l2_wvalid_k3", l2_wvalid, 1'b0);
        chk("t1_busy_k3", busy, 1'b0);

        // Dirty line, L2 always ready
        l2_wready = 1'b1;
        drive_line(26'h0000010, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
        tick();
        evict_valid = 1'b0;
        n = 0; first_vc = -1; first_wv = -1; lastv = '0; wd0 = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vc_wen && first_vc < 0) first_vc = c;
            if (l2_wvalid) begin
                if (first_wv < 0) first_wv = c;
                if (n < 8) begin
                    ad[n] = l2_waddr;
                    lastv[n] = l2_wlast;
                    if (n == 0) wd0 = l2_wdata;
                end
                n++;
            end
        end
        chk("t2_nwords", n, 4);
        chk("t2_addr0", ad[0], 32'h400);
        chk("t2_addr1", ad[1], 32'h404);
        chk("t2_addr2", ad[2], 32'h408);
        chk("t2_addr3", ad[3], 32'h40C);
        chk("t2_wlast", lastv, 8'b0000_1000);
        chk("t2_wdata0", wd0, 32'h11);
        chk("t2_vc_first_vc", first_vc, 0);
        chk("t2_vc_before_wv", first_wv - first_vc, 1);

        // Backpressure on word 2
        tags[0] = TL'($urandom);
        base = {tags[0], 6'b0};
        drive_line(tags[0], rnd_line(), 1'b1);
        tick();
        evict_valid = 1'b0;
        for (int i = 0; i < 20 && !(l2_wvalid && l2_waddr == base + 8); i++) tick();
        chk("t3_found_word2", l2_waddr, base + 8);
        l2_wready = 1'b0;
        hold_a = l2_waddr;
        hold_d = l2_wdata;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_valid", l2_wvalid, 1'b1);
            chk("t3_hold_addr", l2_waddr, hold_a);
            chk("t3_hold_data", l2_wdata, hold_d);
            chk("t3_hold_last", l2_wlast, 1'b0);
        end
        l2_wready = 1'b1;
        chk("t3_resume_word2", l2_waddr, base + 8);
        tick();
        chk("t3_word3_addr", l2_waddr, base + 12);
        chk("t3_word3_last", l2_wlast, 1'b1);
        tick();
        chk("t3_done", l2_wvalid, 1'b0);

        // Full FIFO with L2 stalled
        wait_idle(20);
        l2_wready = 1'b0;
        drive_line(26'h0000100, rnd_line(), 1'b1);
        tick();
        chk("t4_ready_after1", evict_ready, 1'b1);
        drive_line(26'h0000200, rnd_line(), 1'b1);
        tick();
        chk("t4_ready_after2", evict_ready, 1'b0);
        drive_line(26'h0000300, rnd_line(), 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_ready_stall", evict_ready, 1'b0);
        end
        l2_wready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_ready_drain", evict_ready, 1'b0);
        end
        tick();
        chk("t4_ready_after_pop", evict_ready, 1'b1);
        tick();
        chk("t4_third_accepted", evict_ready, 1'b0);
        evict_valid = 1'b0;
        wait_idle(40);

        // Lookup probe during write-back
        l2_wready = 1'b0;
        drive_line(26'h55, rnd_line(), 1'b1);
        tick();
        evict_valid = 1'b0;
        for (int i = 0; i < 10 && !l2_wvalid; i++) tick();
        chk("t5_in_wb", l2_wvalid, 1'b1);
        lookup_tag = 26'h55;
        #1 chk("t5_hit_55", lookup_hit, LOOKUP_ON);
        lookup_tag = 26'h56;
        #1 chk("t5_hit_56", lookup_hit, 1'b0);
        lookup_tag = 26'h55;
        l2_wready  = 1'b1;
        wait_idle(20);
        #1 chk("t5_hit_after_pop", lookup_hit, 1'b0);

        // Reset during burst
        tags[1] = TL'($urandom);
        base = {tags[1], 6'b0};
        drive_line(tags[1], rnd_line(), 1'b1);
        tick();
        drive_line(TL'($urandom), rnd_line(), 1'b1);
        tick();
        evict_valid = 1'b0;
        for (int i = 0; i < 10 && !(l2_wvalid && l2_waddr == base + 4); i++) tick();
        chk("t6_at_word1", l2_waddr, base + 4);
        rst_n = 1'b0;
        #1 chk("t6_wvalid_async", l2_wvalid, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_ready", evict_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_vc_wen", vc_wen, 1'b0);
        end

        // Randomized traffic
        for (int i = 0; i < 4; i++) tags[i] = TL'($urandom);
        for (int c = 0; c < 600; c++) begin
            evict_valid = ($urandom_range(0, 2) == 0);
            evict_tag   = tags[$urandom_range(0, 3)];
            evict_data  = rnd_line();
            evict_dirty = $urandom_range(0, 1) == 1;
            l2_wready   = ($urandom_range(0, 3) != 0);
            lookup_tag  = tags[$urandom_range(0, 3)];
            tick();
        end
        evict_valid = 1'b0;
        l2_wready   = 1'b1;
        wait_idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
